robot_mode_ctrl: RTL

//  Parametrised top-level mode controller for the rover: arbitrates IDLE / CAM-follow / IR-remote modes.

---
 rtl/robot_pkg.sv | 35 +++
 rtl/timeout_counter.sv | 36 +++
 rtl/robot_mode_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/robot_pkg.sv
// Shared types and IR remote key codes for the rover mode controller.
package robot_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_CAM  = 2'b01,
        MODE_IR   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        CAM_SEARCH = 2'b00,
        CAM_FOLLOW = 2'b01,
        CAM_PAUSE  = 2'b11
    } cam_state_t;

    typedef enum logic [2:0] {
        DRV_STOP  = 3'b000,
        DRV_LEFT  = 3'b001,
        DRV_RIGHT = 3'b010,
        DRV_FWD   = 3'b011,
        DRV_REV   = 3'b100
    } drive_cmd_t;

    localparam logic [7:0] CODE_CAM    = 8'h0F;
    localparam logic [7:0] CODE_IR     = 8'h13;
    localparam logic [7:0] CODE_IDLE   = 8'h10;
    localparam logic [7:0] CODE_STOP   = 8'h0C;
    localparam logic [7:0] CODE_LEFT   = 8'h14;
    localparam logic [7:0] CODE_RIGHT  = 8'h18;
    localparam logic [7:0] CODE_FWD    = 8'h1B;
    localparam logic [7:0] CODE_REV    = 8'h1F;
    localparam logic [7:0] CODE_SPD_UP = 8'h1A;
    localparam logic [7:0] CODE_SPD_DN = 8'h1E;

endpackage

// File: rtl/timeout_counter.sv
// Counts enabled cycles; expired flags the cycle on which the LIMIT-th enabled cycle is reached.
// LIMIT=0 disables the counter entirely. RELOAD restarts counting after each expiry instead of holding.
module timeout_counter #(
    parameter int LIMIT  = 16,
    parameter bit RELOAD = 1'b0
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (LIMIT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_cnt
            localparam int W = $clog2(LIMIT + 1);
            logic [W-1:0] cnt_reg;

            assign expired = enable && !clear && (cnt_reg >= W'(LIMIT - 1));

            // Without RELOAD the count saturates at LIMIT so expired stays asserted until cleared.
            always_ff @(posedge clk_50 or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (clear || (RELOAD && expired)) begin
                    cnt_reg <= '0;
                end else if (enable && (cnt_reg < W'(LIMIT))) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/robot_mode_ctrl.sv
// Rover mode controller: IDLE / CAM-follow / IR-remote arbitration with registered drive outputs.
// Optional macro SEARCH_SWEEP_EN: SEARCH alternates RIGHT/LEFT every SWEEP_CYCLES instead of always RIGHT.
module robot_mode_ctrl
    import robot_pkg::*;
#(
    parameter int NUM_SPEEDS   = 3,
    parameter int LOST_CYCLES  = 2_500_000,
    parameter int IR_TIMEOUT   = 50_000_000,
    parameter int SWEEP_CYCLES = 25_000_000,
    localparam int SPD_W       = $clog2(NUM_SPEEDS)
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             ir_valid,
    input  logic [7:0]       ir_code,
    input  logic             target_seen,
    input  logic [1:0]       cam_dir,
    input  logic [SPD_W-1:0] cam_speed,
    output logic [1:0]       mode,
    output logic [1:0]       cam_state,
    output logic [2:0]       drive_cmd,
    output logic [SPD_W-1:0] drive_speed,
    output logic             mode_change
);

    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(NUM_SPEEDS - 1);

    mode_t            mode_reg, mode_next;
    cam_state_t       cam_state_reg, cam_state_next;
    drive_cmd_t       drive_cmd_reg, drive_cmd_next;
    drive_cmd_t       ir_cmd_reg, ir_cmd_next;
    drive_cmd_t       search_cmd;
    logic [SPD_W-1:0] drive_speed_reg, drive_speed_next;
    logic [SPD_W-1:0] ir_speed_reg, ir_speed_next;
    logic             mode_change_reg, mode_change_next;
    logic             lost_expired, wd_expired;

    timeout_counter #(.LIMIT(LOST_CYCLES), .RELOAD(1'b0)) u_lost (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .clear   ((cam_state_reg != CAM_FOLLOW) || target_seen),
        .enable  ((cam_state_reg == CAM_FOLLOW) && !target_seen),
        .expired (lost_expired)
    );

    timeout_counter #(.LIMIT(IR_TIMEOUT), .RELOAD(1'b0)) u_watchdog (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .clear   ((mode_reg != MODE_IR) || ir_valid),
        .enable  ((mode_reg == MODE_IR) && !ir_valid),
        .expired (wd_expired)
    );

`ifdef SEARCH_SWEEP_EN
    logic search_stay, sweep_expired, sweep_left_reg, sweep_left_next;

    assign search_stay = (cam_state_reg == CAM_SEARCH) && (cam_state_next == CAM_SEARCH);

    timeout_counter #(.LIMIT(SWEEP_CYCLES), .RELOAD(1'b1)) u_sweep (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .clear   (!search_stay),
        .enable  (search_stay),
        .expired (sweep_expired)
    );

    assign sweep_left_next = search_stay && (sweep_left_reg ^ sweep_expired);
    assign search_cmd      = sweep_left_next ? DRV_LEFT : DRV_RIGHT;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) sweep_left_reg <= 1'b0;
        else        sweep_left_reg <= sweep_left_next;
    end
`else
    assign search_cmd = DRV_RIGHT;
`endif

    // Mode and CAM sub-state; a mode switch into CAM always lands in SEARCH.
    always_comb begin
        mode_next = mode_reg;
        if (ir_valid) begin
            case (ir_code)
                CODE_CAM:  mode_next = MODE_CAM;
                CODE_IR:   mode_next = MODE_IR;
                CODE_IDLE: mode_next = MODE_IDLE;
                default:   mode_next = mode_reg;
            endcase
        end

        cam_state_next = cam_state_reg;
        if (mode_next != MODE_CAM) begin
            cam_state_next = CAM_PAUSE;
        end else if (mode_reg != MODE_CAM) begin
            cam_state_next = CAM_SEARCH;
        end else begin
            case (cam_state_reg)
                CAM_SEARCH: if (target_seen) cam_state_next = CAM_FOLLOW;
                CAM_FOLLOW: if (lost_expired) cam_state_next = CAM_SEARCH;
                default:    cam_state_next = CAM_SEARCH;
            endcase
        end
    end

    always_comb begin
        ir_cmd_next   = ir_cmd_reg;
        ir_speed_next = ir_speed_reg;
        if (mode_next == MODE_IR) begin
            if (mode_reg != MODE_IR) begin
                ir_cmd_next = DRV_STOP;
            end else if (ir_valid) begin
                case (ir_code)
                    CODE_STOP:   ir_cmd_next = DRV_STOP;
                    CODE_LEFT:   ir_cmd_next = DRV_LEFT;
                    CODE_RIGHT:  ir_cmd_next = DRV_RIGHT;
                    CODE_FWD:    ir_cmd_next = DRV_FWD;
                    CODE_REV:    ir_cmd_next = DRV_REV;
                    CODE_SPD_UP: if (ir_speed_reg < SPD_MAX) ir_speed_next = ir_speed_reg + 1'b1;
                    CODE_SPD_DN: if (ir_speed_reg != '0) ir_speed_next = ir_speed_reg - 1'b1;
                    default:     ir_cmd_next = ir_cmd_reg;
                endcase
            end else if (wd_expired) begin
                ir_cmd_next = DRV_STOP;
            end
        end
    end

    // Drive decode looks at the next mode/sub-state so the motor follows a mode switch immediately.
    always_comb begin
        drive_cmd_next   = DRV_STOP;
        drive_speed_next = '0;
        case (mode_next)
            MODE_CAM: begin
                case (cam_state_next)
                    CAM_SEARCH: drive_cmd_next = search_cmd;
                    CAM_FOLLOW: begin
                        case (cam_dir)
                            2'b01: drive_cmd_next = DRV_LEFT;
                            2'b10: drive_cmd_next = DRV_RIGHT;
                            2'b11: begin
                                drive_cmd_next   = DRV_FWD;
                                drive_speed_next = (cam_speed > SPD_MAX) ? SPD_MAX : cam_speed;
                            end
                            default: drive_cmd_next = DRV_STOP;
                        endcase
                    end
                    default: drive_cmd_next = DRV_STOP;
                endcase
            end
            MODE_IR: begin
                drive_cmd_next   = ir_cmd_next;
                drive_speed_next = ir_speed_next;
            end
            default: begin
                drive_cmd_next   = DRV_STOP;
                drive_speed_next = '0;
            end
        endcase
    end

    assign mode_change_next = (mode_next != mode_reg) || (cam_state_next != cam_state_reg);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg        <= MODE_IDLE;
            cam_state_reg   <= CAM_PAUSE;
            drive_cmd_reg   <= DRV_STOP;
            drive_speed_reg <= '0;
            ir_cmd_reg      <= DRV_STOP;
            ir_speed_reg    <= '0;
            mode_change_reg <= 1'b0;
        end else begin
            mode_reg        <= mode_next;
            cam_state_reg   <= cam_state_next;
            drive_cmd_reg   <= drive_cmd_next;
            drive_speed_reg <= drive_speed_next;
            ir_cmd_reg      <= ir_cmd_next;
            ir_speed_reg    <= ir_speed_next;
            mode_change_reg <= mode_change_next;
        end
    end

    assign mode        = mode_reg;
    assign cam_state   = cam_state_reg;
    assign drive_cmd   = drive_cmd_reg;
    assign drive_speed = drive_speed_reg;
    assign mode_change = mode_change_reg;

endmodule
